mcpu_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle CPU core: same 16-bit instruction word and 8-entry register file, but configurable data/PC widths and a FETCH/EXEC/MEM state machine. Instruction and data memories are reached through req/ack handshakes, so wait-state memories are supported. It sits between the instruction ROM and the data RAM in the top-level system.

---
 rtl/mcpu_core_if.sv | 45 ++++
 rtl/mcpu_core.sv | 255 +++++++++++++++++++++++++
 tb/tb_mcpu_core.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_core_if.sv
// -----------------------------------------------------------------------------
// mcpu_core_if -- instruction/data memory bus of the multi-cycle CPU core.
//
// Both memories use a req/ack handshake: the requester raises *_req and holds
// address/data stable until it sees *_ack high at a rising clock edge.
//
// Signals:
//   i_req   core -> ROM   instruction fetch request
//   i_addr  core -> ROM   fetch address (the program counter)
//   i_ack   ROM  -> core  fetch accepted, i_data valid this cycle
//   i_data  ROM  -> core  16-bit instruction word
//   d_req   core -> RAM   data access request
//   d_we    core -> RAM   1 = store, 0 = load (valid while d_req)
//   d_addr  core -> RAM   data address
//   d_wdata core -> RAM   store data
//   d_ack   RAM  -> core  access complete, d_rdata valid this cycle for loads
//   d_rdata RAM  -> core  load data
//
// Modports: master (core side), slave (memory side).
// -----------------------------------------------------------------------------
interface mcpu_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic              i_req;
  logic [PC_W-1:0]   i_addr;
  logic              i_ack;
  logic [15:0]       i_data;
  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_ack, i_data, d_ack, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_ack, i_data, d_ack, d_rdata
  );
endinterface

// File: rtl/mcpu_core.sv
// -----------------------------------------------------------------------------
// mcpu_core -- multi-cycle 16-bit-instruction CPU core, 8 x DATA_W registers.
//
// States FETCH -> EXEC -> (MEM ->) FETCH, plus HALT. Instruction and data
// memories are reached through the req/ack bus in mcpu_core_if, so memories
// with wait states are supported.
//
// Parameters:
//   DATA_W  register / ALU / data-address width (>= 4)
//   PC_W    program counter / instruction-address width
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   reset_l  asynchronous active-low reset
//   en_l     active-low run enable; a 1->0 transition resumes from HALT
//   bus      mcpu_core_if.master (instruction + data memory handshakes)
//   pc       current program counter
//   halted   core is in the HALT state
//   flags    {Z,N,C,V}; only present when MCPU_FLAGS_EN is defined
//
// Build option: define MCPU_FLAGS_EN to add the flag register, the flags
// port and the BC (BS=4) / BV (BS=5) branch conditions. Without it BS 4-7
// are never taken.
// -----------------------------------------------------------------------------
module mcpu_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic            en_l,
  mcpu_core_if.master     bus,
  output logic [PC_W-1:0] pc,
  output logic            halted
`ifdef MCPU_FLAGS_EN
  ,
  output logic [3:0]      flags
`endif
);

  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;
  localparam logic [3:0] OP_ST   = 4'd4;
  localparam logic [3:0] OP_BR   = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd6;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_t;

  state_t            state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [15:0]       ir_reg;
  logic              halted_reg;
  logic              en_prev_reg;
  logic              d_req_reg;
  logic              d_we_reg;
  logic [DATA_W-1:0] d_addr_reg;
  logic [DATA_W-1:0] d_wdata_reg;
`ifdef MCPU_FLAGS_EN
  logic [3:0]        flags_reg;
  logic [3:0]        flags_next;
`endif

  // Instruction fields
  logic [3:0] op;
  logic [2:0] dr, sa, sb, fs;
  assign op = ir_reg[15:12];
  assign dr = ir_reg[11:9];
  assign sa = ir_reg[8:6];
  assign sb = ir_reg[5:3];
  assign fs = ir_reg[2:0];

  // IMM/OFF sign-extended (or truncated) to the data and PC widths
  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   imm_p;
  assign imm_d = DATA_W'($signed(ir_reg[5:0]));
  assign imm_p = PC_W'($signed(ir_reg[5:0]));

  // Register file: one register per generate slice, read asynchronously
  logic [DATA_W-1:0] rf_q [8];
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rf
      logic [DATA_W-1:0] r_reg;
      always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) r_reg <= '0;
        else if (rf_we && dr == 3'(gi)) r_reg <= rf_wdata;
      end
      assign rf_q[gi] = r_reg;
    end
  endgenerate

  logic [DATA_W-1:0] ra, rb, rd;
  assign ra = rf_q[sa];
  assign rb = rf_q[sb];
  assign rd = rf_q[dr];

  // ALU. ADDI reuses the ADD path with the immediate as B.
  // SUB is A + ~B + 1, so the carry out is the borrow-not.
  logic [DATA_W-1:0] alu_b, b_eff, sum, alu_res;
  logic [2:0]        alu_fs;
  logic              is_sub;
`ifdef MCPU_FLAGS_EN
  logic [DATA_W:0]   sum_full;
  logic              carry, ovf;
`endif

  always_comb begin
    alu_b  = (op == OP_ADDI) ? imm_d : rb;
    alu_fs = (op == OP_ADDI) ? 3'd0 : fs;
    is_sub = (alu_fs == 3'd1);
    b_eff  = is_sub ? ~alu_b : alu_b;
`ifdef MCPU_FLAGS_EN
    sum_full = {1'b0, ra} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    sum      = sum_full[DATA_W-1:0];
    carry    = sum_full[DATA_W];
    ovf      = (ra[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != ra[DATA_W-1]);
`else
    sum      = ra + b_eff + DATA_W'(is_sub);
`endif
    case (alu_fs)
      3'd0, 3'd1: alu_res = sum;
      3'd2:       alu_res = ra & alu_b;
      3'd3:       alu_res = ra | alu_b;
      3'd4:       alu_res = ra ^ alu_b;
      3'd5:       alu_res = ~ra;
      3'd6:       alu_res = ra << 1;
      default:    alu_res = ra >> 1;
    endcase
`ifdef MCPU_FLAGS_EN
    flags_next = {alu_res == '0, alu_res[DATA_W-1],
                  (alu_fs <= 3'd1) ? carry : 1'b0,
                  (alu_fs <= 3'd1) ? ovf : 1'b0};
`endif
  end

  // Branch condition, uses DR field as BS
  logic br_taken;
  always_comb begin
    case (dr)
      3'd0:    br_taken = (ra == '0);
      3'd1:    br_taken = (ra != '0);
      3'd2:    br_taken = ra[DATA_W-1];
      3'd3:    br_taken = 1'b1;
`ifdef MCPU_FLAGS_EN
      3'd4:    br_taken = flags_reg[1];
      3'd5:    br_taken = flags_reg[0];
`endif
      default: br_taken = 1'b0;
    endcase
  end

  logic [PC_W-1:0] pc_plus2, pc_target;
  assign pc_plus2  = pc_reg + PC_W'(2);
  assign pc_target = pc_plus2 + imm_p;

  // Register write-back: ALU/ADDI in EXEC, load data on the MEM ack edge
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    if (state_reg == ST_EXEC && (op == OP_ALU || op == OP_ADDI)) begin
      rf_we = 1'b1;
    end else if (state_reg == ST_MEM && bus.d_ack && !d_we_reg) begin
      rf_we    = 1'b1;
      rf_wdata = bus.d_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_reg   <= ST_FETCH;
      pc_reg      <= '0;
      ir_reg      <= '0;
      halted_reg  <= 1'b0;
      en_prev_reg <= 1'b1;
      d_req_reg   <= 1'b0;
      d_we_reg    <= 1'b0;
      d_addr_reg  <= '0;
      d_wdata_reg <= '0;
`ifdef MCPU_FLAGS_EN
      flags_reg   <= '0;
`endif
    end else begin
      en_prev_reg <= en_l;
      case (state_reg)
        ST_FETCH: begin
          if (!en_l && bus.i_ack) begin
            ir_reg    <= bus.i_data;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_reg <= ST_FETCH;
          case (op)
            OP_ALU, OP_ADDI: begin
              pc_reg <= pc_plus2;
`ifdef MCPU_FLAGS_EN
              flags_reg <= flags_next;
`endif
            end
            OP_LD, OP_ST: begin
              d_req_reg   <= 1'b1;
              d_we_reg    <= (op == OP_ST);
              d_addr_reg  <= ra + imm_d;
              d_wdata_reg <= rd;
              state_reg   <= ST_MEM;
            end
            OP_BR: pc_reg <= br_taken ? pc_target : pc_plus2;
            OP_HALT: begin
              state_reg  <= ST_HALT;
              halted_reg <= 1'b1;
              // Forget the pre-halt enable history so a resume needs a
              // 1->0 transition seen entirely inside HALT.
              en_prev_reg <= 1'b0;
            end
            default: pc_reg <= pc_plus2;
          endcase
        end
        ST_MEM: begin
          if (bus.d_ack) begin
            d_req_reg <= 1'b0;
            pc_reg    <= pc_plus2;
            state_reg <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (en_prev_reg && !en_l) begin
            halted_reg <= 1'b0;
            pc_reg     <= pc_plus2;
            state_reg  <= ST_FETCH;
          end
        end
        default: state_reg <= ST_FETCH;
      endcase
    end
  end

  // Fetch request is combinational; gating with reset_l drops it at once
  // when reset is asserted mid-fetch.
  assign bus.i_req   = (state_reg == ST_FETCH) && !en_l && reset_l;
  assign bus.i_addr  = pc_reg;
  assign bus.d_req   = d_req_reg;
  assign bus.d_we    = d_we_reg;
  assign bus.d_addr  = d_addr_reg;
  assign bus.d_wdata = d_wdata_reg;
  assign pc          = pc_reg;
  assign halted      = halted_reg;
`ifdef MCPU_FLAGS_EN
  assign flags       = flags_reg;
`endif

endmodule

// File: tb/tb_mcpu_core.sv
// -----------------------------------------------------------------------------
// tb_mcpu_core -- bench for mcpu_core (DATA_W = PC_W = 8).
// Directed programs are loaded into a ROM model; the expected bus
// transactions (fetch addresses, load/store address/data) are queued as the
// program is set up, and a responder/monitor pops and compares them each time
// it grants an ack. Timing, PC, HALTED and reset behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_mcpu_core;
  localparam int DW = 8;
  localparam int PW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_l = 1'b0;
  logic          en_l = 1'b0;
  logic [PW-1:0] pc;
  logic          halted;
`ifdef MCPU_FLAGS_EN
  logic [3:0]    flags;
`endif

  mcpu_core_if #(.DATA_W(DW), .PC_W(PW)) bus ();

  logic          i_ack_r = 1'b0;
  logic          d_ack_r = 1'b0;
  logic          late_ack = 1'b0;
  logic [15:0]   i_data_r = 16'h0;
  logic [DW-1:0] d_rdata_r = '0;
  assign bus.i_ack   = i_ack_r | late_ack;
  assign bus.d_ack   = d_ack_r | late_ack;
  assign bus.i_data  = i_data_r;
  assign bus.d_rdata = d_rdata_r;

  mcpu_core #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .en_l    (en_l),
    .bus     (bus),
    .pc      (pc),
    .halted  (halted)
`ifdef MCPU_FLAGS_EN
    ,
    .flags   (flags)
`endif
  );

  logic [15:0]   rom  [128];
  logic [DW-1:0] dmem [256];

  typedef struct {
    bit         is_data;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int i_delay  = 0;
  int d_delay  = 0;
  int i_cnt    = 0;
  int d_cnt    = 0;

  localparam logic [15:0] HALT_W = 16'h6000;

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] d,
                                        input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] f);
    return {op, d, a, b, f};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] d,
                                        input logic [2:0] a, input int imm);
    logic [5:0] im;
    im = 6'(imm);
    return {op, d, a, im};
  endfunction

  task automatic put(input int addr, input logic [15:0] w);
    rom[addr >> 1] = w;
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 128; k++) rom[k] = HALT_W;
    for (int k = 0; k < 256; k++) dmem[k] = 8'(k ^ 8'hA5);
  endtask

  task automatic pf(input int a);
    exp_t e;
    e.is_data = 1'b0; e.we = 1'b0; e.addr = 8'(a); e.wdata = 8'h0;
    exp_q.push_back(e);
  endtask

  task automatic pst(input int a, input int d);
    exp_t e;
    e.is_data = 1'b1; e.we = 1'b1; e.addr = 8'(a); e.wdata = 8'(d);
    exp_q.push_back(e);
  endtask

  task automatic pld(input int a);
    exp_t e;
    e.is_data = 1'b1; e.we = 1'b0; e.addr = 8'(a); e.wdata = 8'h0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end else begin
      $display("check %s = %0h ok", name, got);
    end
  endtask

  task automatic sb_check(input bit is_data, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got data=%0b we=%0b addr=%02h wdata=%02h, expected none",
               is_data, we, addr, wdata);
    end else begin
      e = exp_q.pop_front();
      if (e.is_data !== is_data || e.addr !== addr ||
          (is_data && (e.we !== we || (we && e.wdata !== wdata)))) begin
        n_fail++;
        $display("FAIL sb_txn: got data=%0b we=%0b addr=%02h wdata=%02h, expected data=%0b we=%0b addr=%02h wdata=%02h",
                 is_data, we, addr, wdata, e.is_data, e.we, e.addr, e.wdata);
      end else if (is_data) begin
        $display("txn %s addr=%02h data=%02h ok", we ? "store" : "load ", addr,
                 we ? wdata : dmem[addr]);
      end else begin
        $display("txn fetch addr=%02h ok", addr);
      end
    end
  endtask

  // Memory responder + monitor. An ack raised here completes at the next
  // rising edge, so that is when the transaction is compared.
  always @(negedge clk) begin
    if (!reset_l) begin
      i_ack_r = 1'b0; d_ack_r = 1'b0; i_cnt = 0; d_cnt = 0;
    end else begin
      if (i_ack_r) begin
        i_ack_r = 1'b0;
      end else if (bus.i_req) begin
        if (i_cnt >= i_delay) begin
          i_ack_r  = 1'b1;
          i_cnt    = 0;
          i_data_r = rom[bus.i_addr[7:1]];
          sb_check(1'b0, 1'b0, bus.i_addr, 8'h0);
        end else begin
          i_cnt++;
        end
      end else begin
        i_cnt = 0;
      end

      if (d_ack_r) begin
        d_ack_r = 1'b0;
      end else if (bus.d_req) begin
        if (d_cnt >= d_delay) begin
          d_ack_r = 1'b1;
          d_cnt   = 0;
          if (bus.d_we) dmem[bus.d_addr] = bus.d_wdata;
          else          d_rdata_r = dmem[bus.d_addr];
          sb_check(1'b1, bus.d_we, bus.d_addr, bus.d_wdata);
        end else begin
          d_cnt++;
        end
      end else begin
        d_cnt = 0;
      end
    end
  end

  task automatic wait_halt(input int start, input int max_cyc, output int cyc);
    cyc = start;
    while (!halted && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (!halted) begin
      n_fail++;
      $display("FAIL halt_timeout: halted=%0b after %0d cycles, expected 1", halted, cyc);
    end
  endtask

  task automatic start_reset(input logic en);
    @(posedge clk); #2;
    reset_l = 1'b0;
    en_l    = en;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // ---------------- Test A: ALU, loads/stores with waits, halt/resume ----
    clear_mem();
    i_delay = 0; d_delay = 3;
    put(0,  enc_i(4'd2, 3'd1, 3'd0, 5));        // ADDI R1,R0,5
    put(2,  enc_i(4'd4, 3'd1, 3'd0, 1));        // ST R1,[R0+1]
    put(4,  enc_i(4'd2, 3'd1, 3'd0, -1));       // ADDI R1,R0,-1
    put(6,  enc_r(4'd1, 3'd1, 3'd1, 3'd0, 3'd7)); // R1 <- R1 >> 1
    put(8,  enc_i(4'd4, 3'd1, 3'd0, 4));        // ST R1,[R0+4]
    put(10, enc_i(4'd3, 3'd3, 3'd0, 4));        // LD R3,[R0+4]
    put(12, enc_i(4'd4, 3'd3, 3'd0, 5));        // ST R3,[R0+5]
    put(14, enc_r(4'd1, 3'd2, 3'd1, 3'd1, 3'd0)); // R2 <- R1 + R1
    put(16, enc_i(4'd4, 3'd2, 3'd0, 6));        // ST R2,[R0+6]
    put(18, HALT_W);
    pf(0); pf(2); pst(1, 8'h05); pf(4); pf(6); pf(8); pst(4, 8'h7F);
    pf(10); pld(4); pf(12); pst(5, 8'h7F); pf(14); pf(16); pst(6, 8'hFE); pf(18);

    start_reset(1'b0);
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_i_req", 32'(bus.i_req), 32'h0);
    chk("rst_d_bus", {bus.d_req, bus.d_we, 6'h0, bus.d_addr, bus.d_wdata}, 32'h0);
`ifdef MCPU_FLAGS_EN
    chk("rst_flags", 32'(flags), 32'h0);
`endif
    @(posedge clk); #2;
    reset_l = 1'b1;
    #1;
    chk("first_i_req", 32'(bus.i_req), 32'h1);
    chk("first_i_addr", 32'(bus.i_addr), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pc_after_addi", 32'(pc), 32'h2);
    wait_halt(2, 400, cyc);
    chk("a_cycles", 32'(cyc), 32'd40);
    chk("a_halt_pc", 32'(pc), 32'h12);
`ifdef MCPU_FLAGS_EN
    chk("a_flags", 32'(flags), 32'h5);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("halt_no_i_req", 32'(bus.i_req), 32'h0);
    chk("halt_held", 32'(halted), 32'h1);
    pf(20);
    @(posedge clk); #2; en_l = 1'b1;
    @(posedge clk); #2; en_l = 1'b0;
    @(posedge clk); #1;
    chk("resume_halted", 32'(halted), 32'h0);
    chk("resume_pc", 32'(pc), 32'h14);
    wait_halt(0, 50, cyc);
    chk("a_resume_halt_pc", 32'(pc), 32'h14);
    chk("a_queue_drained", 32'(exp_q.size()), 32'h0);

    // ---------------- Test B: ALU ops, branches, PC wrap, fetch waits ------
    clear_mem();
    exp_q.delete();
    i_delay = 2; d_delay = 0;
    put(0,    enc_i(4'd5, 3'd3, 3'd0, -4));     // BRA -> 0xFE
    put(8'hFE, enc_i(4'd5, 3'd3, 3'd0, 2));     // BRA -> wraps to 0x02
    put(2,  enc_i(4'd2, 3'd1, 3'd0, 12));
    put(4,  enc_i(4'd2, 3'd2, 3'd0, 10));
    put(6,  enc_r(4'd1, 3'd3, 3'd1, 3'd2, 3'd1)); // SUB
    put(8,  enc_r(4'd1, 3'd4, 3'd1, 3'd2, 3'd2)); // AND
    put(10, enc_r(4'd1, 3'd5, 3'd1, 3'd2, 3'd3)); // OR
    put(12, enc_r(4'd1, 3'd6, 3'd1, 3'd2, 3'd4)); // XOR
    put(14, enc_r(4'd1, 3'd7, 3'd1, 3'd0, 3'd5)); // NOT
    put(16, enc_i(4'd4, 3'd3, 3'd0, 0));
    put(18, enc_i(4'd4, 3'd4, 3'd0, 1));
    put(20, enc_i(4'd4, 3'd5, 3'd0, 2));
    put(22, enc_i(4'd4, 3'd6, 3'd0, 3));
    put(24, enc_i(4'd4, 3'd7, 3'd0, 4));
    put(26, enc_r(4'd1, 3'd1, 3'd2, 3'd0, 3'd6)); // R1 <- R2 << 1
    put(28, enc_i(4'd4, 3'd1, 3'd2, -1));        // ST R1,[R2-1]
    put(30, enc_i(4'd5, 3'd1, 3'd0, 4));         // BNZ R0 (not taken)
    put(32, enc_i(4'd5, 3'd0, 3'd0, 2));         // BZ R0 -> 36
    put(36, enc_i(4'd5, 3'd2, 3'd7, 2));         // BN R7 -> 40
    put(40, enc_i(4'd2, 3'd6, 3'd0, 3));
    put(42, enc_i(4'd2, 3'd6, 3'd6, -1));
    put(44, enc_i(4'd5, 3'd1, 3'd6, -4));        // BNZ R6 -> 42
    put(46, enc_i(4'd5, 3'd6, 3'd0, 10));        // BS 6: never
    put(48, enc_i(4'd5, 3'd7, 3'd0, 10));        // BS 7: never
    put(50, enc_i(4'd4, 3'd6, 3'd0, 5));
    put(52, HALT_W);
    pf(0); pf(8'hFE);
    for (int a = 2; a <= 14; a += 2) pf(a);
    pf(16); pst(0, 8'h02); pf(18); pst(1, 8'h08); pf(20); pst(2, 8'h0E);
    pf(22); pst(3, 8'h06); pf(24); pst(4, 8'hF3);
    pf(26); pf(28); pst(9, 8'h14); pf(30); pf(32); pf(36); pf(40);
    for (int k = 0; k < 3; k++) begin pf(42); pf(44); end
    pf(46); pf(48); pf(50); pst(5, 8'h00); pf(52);

    start_reset(1'b0);
    @(posedge clk); #2;
    reset_l = 1'b1;
    wait_halt(0, 600, cyc);
    chk("b_cycles", 32'(cyc), 32'd127);
    chk("b_halt_pc", 32'(pc), 32'h34);
`ifdef MCPU_FLAGS_EN
    chk("b_flags", 32'(flags), 32'hA);
`endif
    chk("b_queue_drained", 32'(exp_q.size()), 32'h0);

    // ---------------- Test C: enable hold, reset mid-load, late ack --------
    clear_mem();
    exp_q.delete();
    i_delay = 0; d_delay = 20;
    put(0, enc_i(4'd2, 3'd1, 3'd0, 7));          // ADDI R1,R0,7
    put(2, enc_i(4'd3, 3'd2, 3'd0, 3));          // LD R2,[R0+3] (never acked)
    start_reset(1'b1);
    @(posedge clk); #2;
    reset_l = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("en_hold_i_req", 32'(bus.i_req), 32'h0);
    chk("en_hold_pc", 32'(pc), 32'h0);
    pf(0); pf(2);
    @(posedge clk); #2;
    en_l = 1'b0;
    cyc = 0;
    while (!bus.d_req && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("c_d_req_seen", 32'(bus.d_req), 32'h1);
    @(posedge clk); #2;
    reset_l = 1'b0;
    #1;
    chk("rst_mid_d_req", 32'(bus.d_req), 32'h0);
    chk("rst_mid_i_req", 32'(bus.i_req), 32'h0);
    chk("rst_mid_pc", 32'(pc), 32'h0);
    @(posedge clk); #2;
    en_l = 1'b1;
    reset_l = 1'b1;
    @(posedge clk); #2;
    late_ack = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    late_ack = 1'b0;
    #1;
    chk("late_ack_pc", 32'(pc), 32'h0);
    chk("late_ack_d_req", 32'(bus.d_req), 32'h0);
    chk("late_ack_halted", 32'(halted), 32'h0);
    // Registers must read back as zero after the reset.
    d_delay = 0;
    put(0, enc_i(4'd4, 3'd1, 3'd0, 2));
    put(2, enc_i(4'd4, 3'd2, 3'd0, 3));
    put(4, HALT_W);
    pf(0); pst(2, 8'h00); pf(2); pst(3, 8'h00); pf(4);
    @(posedge clk); #2;
    en_l = 1'b0;
    wait_halt(0, 50, cyc);
    chk("c_halt_pc", 32'(pc), 32'h4);
    chk("c_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
